// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer RAM between VGA scan-out,
// a buffered pixel writer and a whole-frame fill sequencer.
//
// Scan-out reads always win. Writes go through a small FIFO and use only the
// cycles the reader leaves free. A fill also uses only free cycles, and it
// has priority over draining the FIFO.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rd_req, rd_addr                scan-out read request
//   rd_data, rd_valid              read data (pass-through of mem_rdata), valid 1 cycle later
//   wr_valid, wr_ready             writer handshake (wr_ready = FIFO not full)
//   wr_addr, wr_data               pixel to write
//   fill_start, fill_data          fill request and colour
//   fill_ready, fill_done          fill can start / one-cycle completion pulse
//   fifo_level                     current FIFO occupancy
//   mem_en, mem_we, mem_addr,      RAM port
//   mem_wdata, mem_rdata
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rd_req,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_valid,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              fill_start,
    input  logic [DATA_W-1:0]                 fill_data,
    output logic                              fill_ready,
    output logic                              fill_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {StIdle, StFill} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]   fill_color_q, fill_color_d;
    logic                fill_done_q, fill_done_d;
    logic                rd_valid_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];

    logic                fifo_empty, fifo_full, push, pop;
    logic                port_en, port_we;
    logic [ADDR_W-1:0]   port_addr;
    logic [DATA_W-1:0]   port_wdata;

    // Pointers carry one extra wrap bit: equal => empty, differ only in MSB => full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    // Push ignores a same-cycle pop: a full FIFO never accepts.
    assign push       = wr_valid && !fifo_full;

    assign wr_ready   = !fifo_full;
    assign fill_ready = (state_q == StIdle) && fifo_empty;
    assign fifo_level = LVL_W'(wr_ptr_q - rd_ptr_q);
    assign rd_data    = mem_rdata;
    assign rd_valid   = rd_valid_q;
    assign fill_done  = fill_done_q;

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        fill_done_d  = 1'b0;
        pop          = 1'b0;
        port_en      = 1'b0;
        port_we      = 1'b0;
        port_addr    = '0;
        port_wdata   = '0;

        if (rd_req) begin
            port_en   = 1'b1;
            port_addr = rd_addr;
        end else if (state_q == StFill) begin
            port_en     = 1'b1;
            port_we     = 1'b1;
            port_addr   = fill_addr_q;
            port_wdata  = fill_color_q;
            fill_addr_d = fill_addr_q + 1'b1;
            if (&fill_addr_q) begin
                state_d     = StIdle;
                fill_done_d = 1'b1;
            end
        end else if (!fifo_empty) begin
            port_en    = 1'b1;
            port_we    = 1'b1;
            port_addr  = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
            port_wdata = fifo_data_q[rd_ptr_q[IDX_W-1:0]];
            pop        = 1'b1;
        end

        // fill_ready implies StIdle, where the fill slot above is never taken.
        if (fill_start && fill_ready) begin
            state_d      = StFill;
            fill_addr_d  = '0;
            fill_color_d = fill_data;
        end
    end

    // The RAM port is held quiet for the whole time reset is asserted.
    assign mem_en    = rst_n && port_en;
    assign mem_we    = rst_n && port_we;
    assign mem_addr  = rst_n ? port_addr : '0;
    assign mem_wdata = rst_n ? port_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            fill_done_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            fill_done_q  <= fill_done_d;
            rd_valid_q   <= rd_req;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= wr_addr;
            fifo_data_q[wr_ptr_q[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates the single-port framebuffer RAM between the VGA scan-out reader and the Arduino-side pixel writer inside `tt_um_devinatkin_arduino_vga`. The scan-out path has absolute priority, because pixel timing at 25 MHz cannot stall. Pixel writes are buffered in a small FIFO and retired only on cycles the reader leaves free. A fill sequencer clears or paints the whole framebuffer to one colour, using only the same free cycles.

## Interface
- `ADDR_W`, 12, framebuffer address width; the framebuffer holds 2^ADDR_W pixels.
- `DATA_W`, 6, pixel width (2-bit R, G, B).
- `FIFO_DEPTH`, 4, write FIFO entries; must be a power of 2 and at least 2.
- `clk` in 1: single 25 MHz clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rd_req` in 1: scan-out needs a pixel this cycle.
- `rd_addr` in ADDR_W: scan-out pixel address.
- `rd_data` out DATA_W: pixel data; equals `mem_rdata` (combinational pass-through).
- `rd_valid` out 1: `rd_data` is valid; asserted the cycle after a granted read.
- `wr_valid` in 1: writer presents a pixel.
- `wr_ready` out 1: FIFO can accept; equals not-full.
- `wr_addr` in ADDR_W, `wr_data` in DATA_W: write pixel address and data.
- `fill_start` in 1: one-cycle request to fill the framebuffer.
- `fill_data` in DATA_W: fill colour, sampled on `fill_start`.
- `fill_ready` out 1: high when a `fill_start` would be accepted.
- `fill_done` out 1: one-cycle pulse when a fill completes.
- `fifo_level` out clog2(FIFO_DEPTH+1): current FIFO occupancy.
- `mem_en`, `mem_we` out 1: RAM port enable and write enable.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM port address and write data.
- `mem_rdata` in DATA_W: RAM read data, valid one cycle after a read.

## Operation
- FSM states:
  - IDLE: drains the FIFO.
  - FILL: sweeps the address range.
- Port mux is combinational from `rd_req`, `rd_addr` and registered state. Priority, evaluated every cycle:
  1. `rd_req`=1: `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`. `rd_valid`=1 on the next cycle.
  2. Otherwise, if state is FILL: `mem_en`=1, `mem_we`=1, `mem_addr`=`fill_addr`, `mem_wdata`=latched fill colour. Then `fill_addr` increments.
  3. Otherwise, if the FIFO is not empty: write the FIFO head to the RAM and pop it.
  4. Otherwise: `mem_en`=0.
- FIFO push occurs when `wr_valid && wr_ready`.
  - `wr_ready` = !full. It does not consider a same-cycle pop, so a full FIFO never pushes, even while popping.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
- `fill_ready` = (state==IDLE) && FIFO empty.
  - `fill_start` with `fill_ready`=1: latch `fill_data`, set `fill_addr`=0, enter FILL.
  - `fill_start` with `fill_ready`=0: ignored, no effect.
- During FILL:
  - The FIFO still accepts pushes, but does not pop.
  - Queued writes retire after the fill, so they land on top of the fill colour.
- Fill termination: the FILL-slot write to address 2^ADDR_W−1 moves the FSM to IDLE. `fill_done` pulses on the following cycle. `fill_addr` wraps to 0 and does not re-enter FILL.
- Read coherence: scan-out may read a pixel whose update is still queued. It returns the old RAM value; single-frame tearing is accepted.
- Arithmetic: FIFO read and write pointers are log2(FIFO_DEPTH)+1 bits. Full and empty are decided by the MSB-compare method.

## Timing
- Read latency: 1 cycle (`rd_req` at cycle t gives `rd_valid`/`rd_data` at t+1).
- Write latency, `wr_valid` handshake to RAM write: at least 1 cycle (earliest is the first cycle after the push). It is unbounded while `rd_req` is held high.
- Fill duration: 2^ADDR_W free cycles. With `rd_req`=0 throughout, `fill_done` asserts exactly 2^ADDR_W+1 cycles after the `fill_start` edge.
- Reset values: `rd_valid`, `fill_done`, `fifo_level` = 0; `wr_ready`, `fill_ready` = 1; state IDLE; `fill_addr` = 0.
- While `rst_n`=0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` forced to 0.
- Reset during FILL: abort immediately, empty the FIFO, no `fill_done`; RAM contents are left as-is.

## Test plan
- Read priority: `rd_req`=1 every cycle with FIFO holding 2 entries → zero RAM writes. Drop `rd_req` → the two writes occur on the next two cycles in push order, and `fifo_level` goes 2→1→0.
- FIFO full: with `rd_req`=1, push 4 entries → `wr_ready`=0 and `fifo_level`=4. A 5th `wr_valid` is not accepted and the entry is not lost.
- Read latency: `rd_addr`=0x123 with `mem_rdata` model returning 0x2A → `rd_valid`=1 with `rd_data`=0x2A exactly one cycle later.
- Fill: `ADDR_W`=4, `fill_data`=0x15, `rd_req`=0 → 16 consecutive writes to addresses 0..15, then `fill_done` pulse at cycle 17. Repeat with `rd_req` high on alternate cycles → 32 cycles, no missed address.
- Fill gating and ordering:
  - `fill_start` with FIFO non-empty → ignored.
  - A write to address 3 pushed during FILL → RAM[3] holds the pushed value after `fill_done`.
- Reset mid-fill at `fill_addr`=7 → no further writes, no `fill_done`; `fill_ready`=1 and `fifo_level`=0 after release.
